// File: rtl/div_iter_u32_if.sv
// Operand/result handshake bundle for the iterative divider.
// The master side is the producer/consumer in the execute stage; the slave side is the divider.
interface div_iter_u32_if;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_quotient;
  logic [31:0] o_remainder;
  logic        o_div_by_zero;

  modport master (
    output i_valid, i_dividend, i_divisor, o_ready,
    input  i_ready, o_valid, o_quotient, o_remainder, o_div_by_zero
  );

  modport slave (
    input  i_valid, i_dividend, i_divisor, o_ready,
    output i_ready, o_valid, o_quotient, o_remainder, o_div_by_zero
  );
endinterface

// File: rtl/div_iter_u32.sv
// Multi-cycle 32-bit unsigned restoring divider (quotient + remainder).
// Retires BITS_PER_CYCLE quotient bits per clock; divide-by-zero follows RISC-V results.
module div_iter_u32 #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  div_iter_u32_if.slave bus
);

  localparam int unsigned N_STEPS = 32 / BITS_PER_CYCLE;
  localparam int unsigned CNT_W   = 6;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state, state_nx;
  logic             accept;
  logic [31:0]      d_q, q_q, r_q;
  logic             dbz_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;

  logic [31:0]      r_nx, q_nx, r_sh, diff;
  logic             carry, take;

  // a + b + cin with generate/propagate carry form; carry out set means a >= ~b
  function automatic logic [32:0] cla32(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin);
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 32; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[32], p ^ c[31:0]};
  endfunction

  // Chained restoring steps; r_nx[31] before the shift is the 33rd bit of R'
  always_comb begin
    r_nx  = r_q;
    q_nx  = q_q;
    r_sh  = '0;
    diff  = '0;
    carry = 1'b0;
    take  = 1'b0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      r_sh          = {r_nx[30:0], q_nx[31]};
      {carry, diff} = cla32(r_sh, ~d_q, 1'b1);
      take          = r_nx[31] | carry;
      q_nx          = {q_nx[30:0], take};
      r_nx          = take ? diff : r_sh;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_valid) begin
          accept   = 1'b1;
          state_nx = (bus.i_divisor == 32'd0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == CNT_W'(N_STEPS - 1)) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (bus.o_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand/result registers double as the output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= (state_nx == DONE);
      if (accept) begin
        d_q   <= bus.i_divisor;
        cnt_q <= '0;
        if (bus.i_divisor == 32'd0) begin
          q_q   <= 32'hFFFF_FFFF;
          r_q   <= bus.i_dividend;
          dbz_q <= 1'b1;
        end else begin
          q_q   <= bus.i_dividend;
          r_q   <= '0;
          dbz_q <= 1'b0;
        end
      end else if (state == BUSY) begin
        q_q   <= q_nx;
        r_q   <= r_nx;
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Ready must drop in the same cycle rst is raised, so it is gated by rst directly
  assign bus.i_ready       = (state == IDLE) && !rst;
  assign bus.o_valid       = valid_q;
  assign bus.o_quotient    = q_q;
  assign bus.o_remainder   = r_q;
  assign bus.o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_iter_u32.sv
// Directed + randomized bench for div_iter_u32; the 2- and 4-bit-per-cycle variants
// mirror the main instance's inputs so every result is checked for all three.
module tb_div_iter_u32;

  logic clk;
  logic rst;

  div_iter_u32_if bus  ();
  div_iter_u32_if bus2 ();
  div_iter_u32_if bus4 ();

  div_iter_u32 #(.BITS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus.slave));
  div_iter_u32 #(.BITS_PER_CYCLE(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
  div_iter_u32 #(.BITS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  assign bus2.i_valid    = bus.i_valid;
  assign bus2.i_dividend = bus.i_dividend;
  assign bus2.i_divisor  = bus.i_divisor;
  assign bus2.o_ready    = bus.o_ready;
  assign bus4.i_valid    = bus.i_valid;
  assign bus4.i_dividend = bus.i_dividend;
  assign bus4.i_divisor  = bus.i_divisor;
  assign bus4.o_ready    = bus.o_ready;

  int n_checks = 0;
  int n_errors = 0;
  int got_lat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Results of all three instances against one expected triple
  task automatic chk_res(input string tag, input logic [31:0] eq, input logic [31:0] er,
                         input logic ez);
    chk({tag, "_q1"}, bus.o_quotient, eq);
    chk({tag, "_r1"}, bus.o_remainder, er);
    chk({tag, "_z1"}, 32'(bus.o_div_by_zero), 32'(ez));
    chk({tag, "_q2"}, bus2.o_quotient, eq);
    chk({tag, "_r2"}, bus2.o_remainder, er);
    chk({tag, "_z2"}, 32'(bus2.o_div_by_zero), 32'(ez));
    chk({tag, "_q4"}, bus4.o_quotient, eq);
    chk({tag, "_r4"}, bus4.o_remainder, er);
    chk({tag, "_z4"}, 32'(bus4.o_div_by_zero), 32'(ez));
  endtask

  // One transaction: optional idle gap, result held `hold` cycles with o_ready low
  // while new operands are offered, then handed off. Results checked while o_valid.
  task automatic do_op(input string tag, input logic [31:0] n, input logic [31:0] d,
                       input logic [31:0] eq, input logic [31:0] er, input logic ez,
                       input int pre, input int hold);
    int k;
    repeat (pre) step();
    k = 0;
    while (!bus.i_ready && k < 100) begin
      step();
      k++;
    end
    if (k >= 100) chk({tag, "_ready_timeout"}, 32'(bus.i_ready), 32'd1);
    bus.i_valid    = 1'b1;
    bus.i_dividend = n;
    bus.i_divisor  = d;
    step();
    bus.i_valid = 1'b0;
    got_lat = 1;
    while (!bus.o_valid && got_lat < 100) begin
      step();
      got_lat++;
    end
    if (got_lat >= 100) chk({tag, "_valid_timeout"}, 32'(bus.o_valid), 32'd1);
    chk_res(tag, eq, er, ez);
    for (int h = 0; h < hold; h++) begin
      bus.i_valid    = 1'b1;
      bus.i_dividend = 32'd55;
      bus.i_divisor  = 32'd5;
      step();
      chk({tag, "_hold_q"}, bus.o_quotient, eq);
      chk({tag, "_hold_r"}, bus.o_remainder, er);
      chk({tag, "_hold_ready"}, 32'(bus.i_ready), 32'd0);
      chk({tag, "_hold_valid"}, 32'(bus.o_valid), 32'd1);
    end
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
    step();
    bus.o_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int l1, l2, l4, vcount;
    logic [31:0] rn, rd, eq, er;
    logic        ez;

    rst            = 1'b1;
    bus.i_valid    = 1'b0;
    bus.i_dividend = '0;
    bus.i_divisor  = '0;
    bus.o_ready    = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_q", bus.o_quotient, 32'd0);
    chk("rst_r", bus.o_remainder, 32'd0);
    chk("rst_z", 32'(bus.o_div_by_zero), 32'd0);
    chk("rst_ready", 32'(bus.i_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.i_ready), 32'd1);

    // 100 / 7 with latency for every BITS_PER_CYCLE
    bus.i_valid    = 1'b1;
    bus.i_dividend = 32'd100;
    bus.i_divisor  = 32'd7;
    step();
    bus.i_valid = 1'b0;
    l1 = 0; l2 = 0; l4 = 0;
    for (int k = 1; k <= 40; k++) begin
      if (bus.o_valid  && l1 == 0) l1 = k;
      if (bus2.o_valid && l2 == 0) l2 = k;
      if (bus4.o_valid && l4 == 0) l4 = k;
      step();
    end
    chk("lat_bpc1", 32'(l1), 32'd33);
    chk("lat_bpc2", 32'(l2), 32'd17);
    chk("lat_bpc4", 32'(l4), 32'd9);
    chk_res("d100_7", 32'd14, 32'd2, 1'b0);
    bus.o_ready = 1'b1;
    step();
    bus.o_ready = 1'b0;

    // Boundary operands
    do_op("ffff_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 0, 0);
    do_op("8000_ffff", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 0, 0);
    do_op("ffff_8001", 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0, 1, 0);
    do_op("ffff_fffe", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd1, 1'b0, 0, 0);
    do_op("dead_10", 32'hDEAD_BEEF, 32'h10, 32'h0DEA_DBEE, 32'hF, 1'b0, 0, 0);
    do_op("big_1000", 32'd123456789, 32'd1000, 32'd123456, 32'd789, 1'b0, 2, 0);
    do_op("zero_5", 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 0, 0);
    do_op("five_5", 32'd5, 32'd5, 32'd1, 32'd0, 1'b0, 0, 0);

    // Divide by zero, then a normal op
    do_op("dbz", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0, 0);
    chk("dbz_lat", 32'(got_lat), 32'd1);
    do_op("after_dbz", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 0, 0);
    chk("after_dbz_lat", 32'(got_lat), 32'd33);

    // Backpressure: result held 10 cycles while other operands are offered
    do_op("hold", 32'd7, 32'd100, 32'd0, 32'd7, 1'b0, 0, 10);
    chk("hold_idle_ready", 32'(bus.i_ready), 32'd1);
    chk("hold_idle_valid", 32'(bus.o_valid), 32'd0);
    do_op("after_hold", 32'd55, 32'd5, 32'd11, 32'd0, 1'b0, 0, 0);

    // Reset mid-operation
    bus.i_valid    = 1'b1;
    bus.i_dividend = 32'd123456;
    bus.i_divisor  = 32'd789;
    step();
    bus.i_valid = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    chk("midrst_ready", 32'(bus.i_ready), 32'd0);
    chk("midrst_valid", 32'(bus.o_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_ready_after", 32'(bus.i_ready), 32'd1);
    vcount = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.o_valid || bus2.o_valid || bus4.o_valid) vcount++;
      step();
    end
    chk("midrst_no_valid", 32'(vcount), 32'd0);
    do_op("after_rst", 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 0, 0);

    // Randomized operands and throttling against the language's / and %
    for (int t = 0; t < 300; t++) begin
      rn = $urandom;
      case ($urandom_range(0, 9))
        0:       rd = 32'd0;
        1, 2, 3: rd = $urandom >> $urandom_range(0, 31);
        4:       rd = 32'(1) << $urandom_range(0, 31);
        default: rd = $urandom;
      endcase
      if (rd == 32'd0) begin
        eq = 32'hFFFF_FFFF;
        er = rn;
        ez = 1'b1;
      end else begin
        eq = rn / rd;
        er = rn % rd;
        ez = 1'b0;
      end
      do_op("rand", rn, rd, eq, er, ez, int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
